// File: rtl/up_count.sv
// Synchronous up counter built from per-bit T flip-flops with an AND-chain carry.
// Supports parallel load, programmable modulus, cascade carry-out and a sticky wrap flag.

module up_count_tff (
   input  logic clk,
   input  logic reset,
   input  logic t,
   input  logic sclr,
   input  logic ld,
   input  logic ld_val,
   output logic q
);
   logic q_q, q_d;

   always_comb begin
      q_d = q_q ^ t;
      if (sclr) q_d = 1'b0;
      if (ld)   q_d = ld_val;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) q_q <= 1'b0;
      else       q_q <= q_d;
   end

   assign q = q_q;
endmodule

module up_count #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             ovf,
   output logic             load_err
);
   // One extra bit so MODULUS = 2^WIDTH is representable in the compares.
   localparam logic [WIDTH:0] MOD_W = MODULUS[WIDTH:0];
   localparam logic [WIDTH:0] MAX_W = MOD_W - (WIDTH+1)'(1);

   logic [WIDTH-1:0] t;
   logic             at_max, d_ok, wrap;
   logic             ovf_q, ovf_d, load_err_q, load_err_d;

   assign at_max = ({1'b0, q} == MAX_W);
   assign d_ok   = ({1'b0, d} < MOD_W);
   assign wrap   = en & at_max & ~load;
   assign tc     = en & at_max;

   assign t[0] = en;
   genvar gi;
   generate
      for (gi = 1; gi < WIDTH; gi++) begin : g_carry
         assign t[gi] = t[gi-1] & q[gi-1];
      end
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         up_count_tff u_tff (
            .clk    (clk),
            .reset  (reset),
            .t      (t[gi]),
            .sclr   (wrap),
            .ld     (load),
            .ld_val (d[gi] & d_ok),
            .q      (q[gi])
         );
      end
   endgenerate

   // A wrap on the same edge as clr_ovf keeps the flag set.
   always_comb begin
      ovf_d = ovf_q;
      if (clr_ovf) ovf_d = 1'b0;
      if (wrap)    ovf_d = 1'b1;
      load_err_d = load & ~d_ok;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q      <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         ovf_q      <= ovf_d;
         load_err_q <= load_err_d;
      end
   end

   assign ovf      = ovf_q;
   assign load_err = load_err_q;
endmodule

// File: tb/tb_up_count.sv
// Scoreboard bench for up_count: default, MODULUS=10, and a two-stage cascade.

module tb_up_count;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {logic tc; logic [3:0] q; logic ovf; logic le;} exp_t;
   typedef struct packed {logic [3:0] q; logic ovf; logic le;} st_t;

   logic       rst0, en0, ld0, clr0, tc0, ovf0, le0;
   logic [3:0] d0, q0;
   logic       rstr, en1, ld1, clr1, tc1, ovf1, le1;
   logic [3:0] d1, q1;
   logic       enc, tc_lo, tc_hi, ovf_lo, ovf_hi, le_lo, le_hi;
   logic [3:0] q_lo, q_hi;
   logic [3:0] zero4 = 4'd0;
   logic       zero1 = 1'b0;

   up_count u0 (.clk(clk), .reset(rst0), .en(en0), .load(ld0), .d(d0), .clr_ovf(clr0),
                .q(q0), .tc(tc0), .ovf(ovf0), .load_err(le0));
   up_count #(.WIDTH(4), .MODULUS(10)) u1 (.clk(clk), .reset(rstr), .en(en1), .load(ld1), .d(d1),
                .clr_ovf(clr1), .q(q1), .tc(tc1), .ovf(ovf1), .load_err(le1));
   up_count c0 (.clk(clk), .reset(rstr), .en(enc), .load(zero1), .d(zero4), .clr_ovf(zero1),
                .q(q_lo), .tc(tc_lo), .ovf(ovf_lo), .load_err(le_lo));
   up_count c1 (.clk(clk), .reset(rstr), .en(tc_lo), .load(zero1), .d(zero4), .clr_ovf(zero1),
                .q(q_hi), .tc(tc_hi), .ovf(ovf_hi), .load_err(le_hi));

   exp_t       sb0[$], sb1[$];
   logic [7:0] sbc[$];
   st_t        m0, m1;
   logic       tc0_s, tc1_s;
   int         checks = 0, failures = 0;

   function automatic st_t nxt(st_t s, int md, logic en, logic ld, logic [3:0] d, logic clr);
      st_t n = s;
      n.le = 1'b0;
      if (clr) n.ovf = 1'b0;
      if (ld) begin
         if (int'(d) < md) n.q = d;
         else begin n.q = 4'd0; n.le = 1'b1; end
      end else if (en) begin
         if (int'(s.q) == md - 1) begin n.q = 4'd0; n.ovf = 1'b1; end
         else n.q = s.q + 4'd1;
      end
      return n;
   endfunction

   // Called at posedge+1 (or up to +7); predicts the edge, samples tc, returns at next posedge+1.
   task automatic tick(input bit p0, input bit p1);
      exp_t e;
      e.tc = en0 && (m0.q == 4'd15);
      m0 = nxt(m0, 16, en0, ld0, d0, clr0);
      e.q = m0.q; e.ovf = m0.ovf; e.le = m0.le;
      if (p0) sb0.push_back(e);
      e.tc = en1 && (m1.q == 4'd9);
      m1 = nxt(m1, 10, en1, ld1, d1, clr1);
      e.q = m1.q; e.ovf = m1.ovf; e.le = m1.le;
      if (p1) sb1.push_back(e);
      #2;
      tc0_s = tc0; tc1_s = tc1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst0 = 1'b1; rstr = 1'b1;
      en0 = 1'b1; ld0 = 1'b0; d0 = 4'd0; clr0 = 1'b0;
      en1 = 1'b0; ld1 = 1'b0; d1 = 4'd0; clr1 = 1'b0; enc = 1'b0;
      m0 = '0; m1 = '0;
      #1;
      checks++; if (q0 !== 4'd0)  begin failures++; $display("FAIL reset_q got=%0d exp=0", q0); end
      checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf0); end
      checks++; if (le0 !== 1'b0)  begin failures++; $display("FAIL reset_le got=%b exp=0", le0); end
      checks++; if (tc0 !== 1'b0)  begin failures++; $display("FAIL reset_tc got=%b exp=0", tc0); end
      #9;
      rst0 = 1'b0; rstr = 1'b0;
   endtask

   task automatic test_count();
      exp_t e;
      en0 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, 1'b0);
         e = sb0.pop_front();
         checks++;
         if ({tc0_s, q0, ovf0, le0} !== e) begin
            failures++;
            $display("FAIL count cyc=%0d got(tc,q,ovf,le)=%b/%0d/%b/%b exp=%b/%0d/%b/%b",
                     i, tc0_s, q0, ovf0, le0, e.tc, e.q, e.ovf, e.le);
         end
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      en0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0);
         e = sb0.pop_front();
         checks++;
         if ({tc0_s, q0, ovf0, le0} !== e) begin
            failures++;
            $display("FAIL pre_reset cyc=%0d got q=%0d ovf=%b exp q=%0d ovf=%b", i, q0, ovf0, e.q, e.ovf);
         end
      end
      #3 rst0 = 1'b1;
      m0 = '0;
      #1;
      checks++; if (q0 !== 4'd0)   begin failures++; $display("FAIL async_q got=%0d exp=0", q0); end
      checks++; if (ovf0 !== 1'b0) begin failures++; $display("FAIL async_ovf got=%b exp=0", ovf0); end
      #2 rst0 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0);
         e = sb0.pop_front();
         checks++;
         if ({tc0_s, q0, ovf0, le0} !== e) begin
            failures++;
            $display("FAIL post_reset cyc=%0d got q=%0d exp q=%0d", i, q0, e.q);
         end
      end
   endtask

   task automatic test_load();
      exp_t e;
      en0 = 1'b1; ld0 = 1'b1; d0 = 4'd9;
      tick(1'b1, 1'b0);
      e = sb0.pop_front();
      checks++;
      if ({tc0_s, q0, ovf0, le0} !== e) begin
         failures++;
         $display("FAIL load9 got q=%0d le=%b exp q=%0d le=%b", q0, le0, e.q, e.le);
      end
      ld0 = 1'b0; en0 = 1'b0;
      tick(1'b1, 1'b0);
      e = sb0.pop_front();
      checks++;
      if ({tc0_s, q0, ovf0, le0} !== e) begin
         failures++;
         $display("FAIL load9_hold got q=%0d exp q=%0d", q0, e.q);
      end
      en1 = 1'b1; ld1 = 1'b1; d1 = 4'd12;
      tick(1'b0, 1'b1);
      e = sb1.pop_front();
      checks++;
      if ({tc1_s, q1, ovf1, le1} !== e) begin
         failures++;
         $display("FAIL load12 got q=%0d le=%b exp q=%0d le=%b", q1, le1, e.q, e.le);
      end
      ld1 = 1'b0; en1 = 1'b0;
      tick(1'b0, 1'b1);
      e = sb1.pop_front();
      checks++;
      if ({tc1_s, q1, ovf1, le1} !== e) begin
         failures++;
         $display("FAIL load12_next got q=%0d le=%b exp q=%0d le=%b", q1, le1, e.q, e.le);
      end
   endtask

   task automatic test_mod10();
      exp_t e;
      en1 = 1'b1;
      // 13 counts from 0 to 3, clear at 3, 5 counts to 9, clear on the wrap edge.
      for (int i = 0; i < 20; i++) begin
         clr1 = (i == 13 || i == 19);
         tick(1'b0, 1'b1);
         e = sb1.pop_front();
         checks++;
         if ({tc1_s, q1, ovf1, le1} !== e) begin
            failures++;
            $display("FAIL mod10 cyc=%0d got(tc,q,ovf)=%b/%0d/%b exp=%b/%0d/%b",
                     i, tc1_s, q1, ovf1, e.tc, e.q, e.ovf);
         end
      end
      checks++;
      if (ovf1 !== 1'b1) begin failures++; $display("FAIL mod10_wrap_clr got ovf=%b exp=1", ovf1); end
      clr1 = 1'b0; en1 = 1'b0;
      tick(1'b0, 1'b0);
   endtask

   task automatic test_hold();
      exp_t e;
      ld0 = 1'b1; d0 = 4'd5; en0 = 1'b0;
      tick(1'b1, 1'b0);
      void'(sb0.pop_front());
      ld0 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         en0 = (i == 3);
         tick(1'b1, 1'b0);
         e = sb0.pop_front();
         checks++;
         if ({tc0_s, q0, ovf0, le0} !== e) begin
            failures++;
            $display("FAIL hold cyc=%0d got(tc,q)=%b/%0d exp=%b/%0d", i, tc0_s, q0, e.tc, e.q);
         end
      end
      en0 = 1'b0;
   endtask

   task automatic test_cascade();
      logic [7:0] cnt = 8'd0, ex;
      enc = 1'b1;
      for (int i = 0; i < 256; i++) begin
         cnt = cnt + 8'd1;
         sbc.push_back(cnt);
         tick(1'b0, 1'b0);
         ex = sbc.pop_front();
         checks++;
         if ({q_hi, q_lo} !== ex) begin
            failures++;
            $display("FAIL cascade cyc=%0d got=%h exp=%h", i, {q_hi, q_lo}, ex);
         end
      end
      checks++;
      if (ovf_hi !== 1'b1) begin failures++; $display("FAIL cascade_ovf got=%b exp=1", ovf_hi); end
      enc = 1'b0;
   endtask

   initial begin
      test_reset();
      test_count();
      test_async_reset();
      test_load();
      test_mod10();
      test_hold();
      test_cascade();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/up_count.md
Name: up_count

Overview:
- Synchronous up counter: the count-up counterpart of the team's structural 4-bit down counter (`count`).
- Built from per-bit T flip-flops with AND-chain toggle logic, so all bits change on the same clock edge.
- Adds parallel load, count enable, a programmable modulus, terminal-count carry for cascading, and a sticky overflow flag.
- Used as a cycle/event counter and as a cascadable stage for wider counters.

Parameters:
- WIDTH, 4, counter width in bits (legal 2..16).
- MODULUS, 16, count sequence is 0..MODULUS-1 (legal 2..2^WIDTH).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- en, input, 1, count enable; also acts as cascade carry-in.
- load, input, 1, synchronous parallel load strobe.
- d, input, WIDTH, parallel load value.
- clr_ovf, input, 1, synchronous clear of ovf.
- q, output, WIDTH, current count.
- tc, output, 1, terminal count / carry-out (combinational).
- ovf, output, 1, sticky wrap flag (registered).
- load_err, output, 1, one-cycle flag: last load value was out of range (registered).

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - While reset=1: q=0, ovf=0, load_err=0, independent of clk.
  - tc=0 while reset=1, because it is qualified by en and q=0 is not terminal when MODULUS>1.
  - First count after reset release happens on the first rising edge with en=1 and reset=0.
- Priority at each rising edge: reset > load > en > hold.
- Load (load=1):
  - If d < MODULUS: q <= d and load_err <= 0.
  - If d >= MODULUS: q <= 0 and load_err <= 1.
  - en is ignored on that edge.
  - ovf is not set by a load.
- Count (load=0, en=1):
  - If q < MODULUS-1: q <= q+1.
  - If q == MODULUS-1: q <= 0 and ovf <= 1.
  - load_err <= 0.
- Hold (load=0, en=0): q holds; load_err <= 0.
  - load_err is therefore high for exactly the one cycle after an out-of-range load.
- tc = en & (q == MODULUS-1), combinational with zero latency.
  - Cascading: drive the next stage's en from this stage's tc.
- ovf:
  - Set on any counted wrap.
  - Cleared when clr_ovf=1 at an edge.
  - If a wrap and clr_ovf=1 occur on the same edge, the set wins (ovf=1).
- Full-range case (MODULUS=2^WIDTH): wrap is natural binary rollover. The range-check logic still synthesizes and never asserts load_err.
- Reset asserted mid-count or mid-load: outputs go to reset values immediately. No partial update survives.
- Structure:
  - Each bit i is a TFF whose toggle input is the AND of en with all lower q bits.
  - Wrap detection forces a synchronous clear at MODULUS-1.
  - Load muxes d into the TFF D-path.
  - No behavioural `+` on q.

Test Plan:
- Reset=1 for 10 ns, then reset=0, en=1, run 20 cycles (defaults) -> q steps 0,1,…,15,0,1,2,3; tc=1 exactly while q=15; ovf rises on the 15->0 edge and stays 1.
- Assert reset asynchronously mid-cycle at q=7 (not on an edge) -> q=0, ovf=0 immediately, before the next clk edge; counting resumes from 0 after release.
- load=1, d=4'd9, en=1 on one edge -> q=9, no increment that cycle; with MODULUS=10, d=4'd12 -> q=0, load_err=1 for one cycle, then 0.
- MODULUS=10, en=1 from q=0 -> sequence 0..9,0; tc high only at q=9; ovf set at the 9->0 wrap; assert clr_ovf at q=3 -> ovf=0; clr_ovf on the same edge as the wrap -> ovf stays 1.
- Toggle en: en=0 for 3 cycles at q=5 -> q holds 5 and tc=0; a 2-stage cascade (stage1.en = stage0.tc) counts 0x00..0xFF and rolls over to 0x00.
